// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands and result are registered; one operation in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter #(
  parameter int N    = 64,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [N-1:0]    req_a0,
  input  logic [N-1:0]    req_a1,
  input  logic [N-1:0]    req_b0,
  input  logic [N-1:0]    req_b1,
  input  logic [3:0]      req_ctrl0,
  input  logic [3:0]      req_ctrl1,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [N-1:0]    rsp_result,
  output logic            rsp_zero,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [N-1:0]    alu_result,
  input  logic            alu_zero,
  output logic            busy,
  output logic [CNTW-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ctrl;
  } req_t;

  state_t         state, state_nxt;
  req_t [1:0]     reqs;
  logic           last_grant, owner, win, accept;

  assign reqs[0] = '{a: req_a0, b: req_b0, ctrl: req_ctrl0};
  assign reqs[1] = '{a: req_a1, b: req_b1, ctrl: req_ctrl1};

  // On a tie the requester not served last wins; otherwise whoever is asking.
  always_comb begin
    if (&req_valid) win = ~last_grant;
    else            win = req_valid[1];
  end

  assign accept = (state == IDLE) && (|req_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    if (accept) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      ops_done   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          {alu_a, alu_b, alu_ctrl} <= reqs[win];
          owner                    <= win;
        end
        EXEC: begin
          rsp_result       <= alu_result;
          rsp_zero         <= alu_zero;
          rsp_valid[owner] <= 1'b1;
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid  <= '0;
          last_grant <= owner;
          ops_done   <= ops_done + {{(CNTW-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached to the alu_* port.
module tb_alu_arbiter;
  localparam int N    = 64;
  localparam int CNTW = 8;  // narrow counter keeps the wrap check short

  logic            clk, reset;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0]    req_a0, req_a1, req_b0, req_b1;
  logic [3:0]      req_ctrl0, req_ctrl1, alu_ctrl;
  logic [N-1:0]    rsp_result, alu_a, alu_b, alu_result;
  logic            rsp_zero, alu_zero, busy;
  logic [CNTW-1:0] ops_done, exp_ops;

  typedef struct {
    logic [1:0]   vld;
    logic [N-1:0] res;
    logic         z;
    logic [N-1:0] a;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.N(N), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .ops_done(ops_done)
  );

  function automatic logic [N-1:0] alu_fn(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1100: return ~(a | b);
      default: return '1;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int w, input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] c);
    if (w == 0) begin req_a0 = a; req_b0 = b; req_ctrl0 = c; end
    else        begin req_a1 = a; req_b1 = b; req_ctrl1 = c; end
    req_valid[w] = 1'b1;
  endtask

  // Waits for the expected grant, then follows the op through EXEC and RESP.
  task automatic serve(input int w, input logic [N-1:0] eres, input logic ez, input bit drop, input int stall);
    int   n;
    exp_t e;
    logic [1:0] oh;
    oh = 2'b01 << w;
    n  = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (req_ready !== oh) begin
      errors++; $display("FAIL grant: req_ready got %b want %b", req_ready, oh);
    end
    e.vld = oh; e.res = eres; e.z = ez; e.a = (w == 0) ? req_a0 : req_a1;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    if (drop) req_valid[w] = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b1 || req_ready !== 2'b00) begin
      errors++; $display("FAIL exec: rsp_valid=%b busy=%b req_ready=%b want 00/1/00", rsp_valid, busy, req_ready);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== e.vld) begin
      errors++; $display("FAIL rsp_valid: got %b want %b", rsp_valid, e.vld);
    end
    checks++;
    if (rsp_result !== e.res || rsp_zero !== e.z) begin
      errors++; $display("FAIL result: got %h/%b want %h/%b", rsp_result, rsp_zero, e.res, e.z);
    end
    if (stall > 0) begin
      rsp_ready = ~e.vld;
      repeat (stall) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== e.vld || rsp_result !== e.res || alu_a !== e.a || req_ready !== 2'b00 || busy !== 1'b1) begin
          errors++;
          $display("FAIL stall: rsp_valid=%b res=%h alu_a=%h req_ready=%b busy=%b want %b %h %h 00 1",
                   rsp_valid, rsp_result, alu_a, req_ready, busy, e.vld, e.res, e.a);
        end
      end
      rsp_ready = e.vld;
    end
    @(negedge clk);
    exp_ops++;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || ops_done !== exp_ops) begin
      errors++; $display("FAIL done: busy=%b rsp_valid=%b ops_done=%0d want 0 00 %0d", busy, rsp_valid, ops_done, exp_ops);
    end
    rsp_ready = 2'b11;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== '0 || rsp_zero !== 1'b0 ||
        alu_a !== '0 || alu_b !== '0 || alu_ctrl !== 4'h0 || busy !== 1'b0 || ops_done !== '0) begin
      errors++;
      $display("FAIL %s: rr=%b rv=%b res=%h z=%b a=%h b=%h c=%h busy=%b ops=%0d want all zero",
               tag, req_ready, rsp_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_ctrl, busy, ops_done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b0; exp_ops = '0; sb.delete();
    #1 check_zero("post_reset");
  endtask

  task automatic test_single_add();
    set_req(0, 64'd5, 64'd7, 4'b0010);
    serve(0, 64'd12, 1'b0, 1'b1, 0);
  endtask

  task automatic test_sub_zero();
    set_req(1, 64'd9, 64'd9, 4'b0110);
    serve(1, 64'd0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    set_req(0, 64'd3, 64'd5, 4'b0001);
    set_req(1, 64'd12, 64'd10, 4'b0000);
    for (int k = 0; k < 4; k++) serve(k % 2, (k % 2 == 0) ? 64'd7 : 64'd8, 1'b0, 1'b0, 0);
    req_valid = 2'b00;
  endtask

  task automatic test_stall();
    set_req(0, 64'd20, 64'd22, 4'b0010);
    serve(0, 64'd42, 1'b0, 1'b1, 5);
  endtask

  task automatic test_reset_exec();
    int n;
    set_req(1, 64'd1, 64'd2, 4'b0010);
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL rst_grant: req_ready got %b want 10", req_ready);
    end
    @(posedge clk); @(negedge clk);
    req_valid = 2'b00;
    reset = 1'b1;
    #1 check_zero("reset_exec");
    @(negedge clk);
    reset = 1'b0; exp_ops = '0; sb.delete();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++; $display("FAIL dropped: rsp_valid=%b busy=%b want 00 0", rsp_valid, busy);
      end
    end
    // last grant before reset was requester 0, so this tie proves last_grant was reinitialised
    set_req(0, 64'd3, 64'd5, 4'b0001);
    set_req(1, 64'd12, 64'd10, 4'b0000);
    serve(0, 64'd7, 1'b0, 1'b1, 0);
    serve(1, 64'd8, 1'b0, 1'b1, 0);
  endtask

  task automatic test_undef_wrap();
    logic [CNTW-1:0] prev;
    bit wrapped;
    set_req(0, 64'd0, 64'd0, 4'b1111);
    serve(0, '1, 1'b0, 1'b1, 0);
    wrapped = 1'b0;
    for (int i = 0; i < 300 && !wrapped; i++) begin
      prev = exp_ops;
      set_req(i % 2, 64'(i), 64'd1, 4'b0010);
      serve(i % 2, 64'(i) + 64'd1, 1'b0, 1'b1, 0);
      if (prev == '1) wrapped = 1'b1;
    end
    checks++;
    if (!wrapped || ops_done !== '0) begin
      errors++; $display("FAIL wrap: ops_done=%0d wrapped=%0d want 0 1", ops_done, wrapped);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b11;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_ctrl0 = '0; req_ctrl1 = '0;
    exp_ops = '0;
    test_reset();
    test_single_add();
    test_sub_zero();
    test_reset();
    test_back_to_back();
    test_stall();
    test_reset_exec();
    test_undef_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
